// File: rtl/crc_pkg.sv
// crc_pkg: CRC constants, receiver state type and the bytewise CRC-8 step shared by both link sides
package crc_pkg;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    localparam logic [4:0] CRC5_POLY = 5'h05;

    typedef enum logic [1:0] {COLLECT, DRAIN, HOLD} rx_state_t;

    function automatic logic [7:0] crc8_byte_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? {c[6:0], 1'b0} ^ CRC8_POLY : {c[6:0], 1'b0};
        return c;
    endfunction
endpackage

// File: rtl/crc8_byte_step.sv
// crc8_byte_step: combinational CRC-8 update by one byte, eight MSB-first division steps unrolled
module crc8_byte_step
    import crc_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);
    always_comb begin
        crc_next = crc ^ data;
        for (int i = 0; i < 8; i++) crc_next = crc_next[7] ? {crc_next[6:0], 1'b0} ^ CRC8_POLY : {crc_next[6:0], 1'b0};
    end
endmodule

// File: rtl/crc8_frame_receiver.sv
// crc8_frame_receiver: byte-serial CRC-8 codeword receiver producing a data word with crc/length error flags
module crc8_frame_receiver
    import crc_pkg::*;
#(
    parameter int DATA_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DATA_BYTES-1:0] out_data,
    output logic                    out_crc_err,
    output logic                    out_len_err
);
    localparam int W  = 8 * DATA_BYTES;
    localparam int CW = $clog2(DATA_BYTES + 2);
    localparam logic [CW-1:0] CRC_IDX = CW'(DATA_BYTES);

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [7:0]    crc;
    logic [7:0]    crc_next;
    logic [W-1:0]  data_sr;
    logic          crc_err;
    logic          len_err;
    logic          take;

    crc8_byte_step u_step (.crc(crc), .data(in_data), .crc_next(crc_next));

    assign in_ready    = state != HOLD;
    assign out_valid   = state == HOLD;
    assign out_data    = data_sr;
    assign out_crc_err = crc_err;
    assign out_len_err = len_err;
    assign take        = in_valid && in_ready;

    // cnt never passes CRC_IDX+1: DRAIN leaves it where the CRC byte put it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= COLLECT;
            cnt     <= '0;
            crc     <= CRC8_INIT;
            data_sr <= '0;
            crc_err <= 1'b0;
            len_err <= 1'b0;
        end else begin
            case (state)
                COLLECT: if (take) begin
                    crc <= crc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt != CRC_IDX) data_sr <= W'({data_sr, in_data});
                    if (in_last) begin
                        state   <= HOLD;
                        len_err <= cnt != CRC_IDX;
                        crc_err <= cnt != CRC_IDX || crc_next != 8'h00;
                    end else if (cnt == CRC_IDX) begin
                        state   <= DRAIN;
                        len_err <= 1'b1;
                        crc_err <= crc_next != 8'h00;
                    end
                end
                DRAIN: if (take && in_last) state <= HOLD;
                HOLD: if (out_ready) begin
                    state   <= COLLECT;
                    cnt     <= '0;
                    crc     <= CRC8_INIT;
                    data_sr <= '0;
                    crc_err <= 1'b0;
                    len_err <= 1'b0;
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_crc8_frame_receiver.sv
// tb_crc8_frame_receiver: directed frames checked against a polynomial-division model and literal expectations
module tb_crc8_frame_receiver;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [8*D-1:0] out_data;
    logic          out_crc_err;
    logic          out_len_err;

    crc8_frame_receiver #(.DATA_BYTES(D)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_crc_err(out_crc_err), .out_len_err(out_len_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    logic [7:0]  mq[$];
    bit          exp_valid = 1'b0;
    logic [63:0] exp_data = '0;
    bit          exp_crc = 1'b0;
    bit          exp_len = 1'b0;

    // remainder of (message * x^8) mod x^8+x^2+x+1 by plain bitwise long division
    function automatic logic [7:0] rem8(input logic [7:0] b[$], input int n);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < n * 8 + 8; i++) begin
            r = {r[7:0], (i < n * 8) ? b[i / 8][7 - i % 8] : 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic void predict();
        int n;
        n = mq.size();
        exp_len = n != D + 1;
        exp_crc = (n <= D) ? 1'b1 : (rem8(mq, D + 1) != 8'h00);
        exp_data = '0;
        for (int i = 0; i < ((n < D) ? n : D); i++) exp_data = (exp_data << 8) | 64'(mq[i]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_valid = 1'b0;
        end else if (exp_valid) begin
            if (out_ready) begin
                exp_valid = 1'b0;
                mq.delete();
            end
        end else if (in_valid) begin
            mq.push_back(in_data);
            if (in_last) begin
                predict();
                exp_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", out_data, 64'd0);
            chk("rst_flags", {62'd0, out_crc_err, out_len_err}, 64'd0);
        end else begin
            chk("model_in_ready", 64'(in_ready), 64'(!exp_valid));
            chk("model_out_valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid) begin
                chk("model_out_data", out_data, exp_data);
                chk("model_crc_err", 64'(out_crc_err), 64'(exp_crc));
                chk("model_len_err", 64'(out_len_err), 64'(exp_len));
            end
        end
    end

    task automatic send(input logic [7:0] b[$], input bit last);
        bit ok;
        int n;
        for (int i = 0; i < b.size(); i++) begin
            in_valid = 1'b1;
            in_data = b[i];
            in_last = last && (i == b.size() - 1);
            n = 0;
            do begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < 50);
            if (!ok) chk("send_timeout", 64'(ok), 64'd1);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [63:0] d, input bit c, input bit l, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_crc_err"}, 64'(out_crc_err), 64'(c));
        chk({name, "_len_err"}, 64'(out_len_err), 64'(l));
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [7:0] f_zero[$], f_one[$], f_bad[$], f_100[$], f_short[$], f_long[$], f_part[$];

    initial begin
        f_zero  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        f_one   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h07};
        f_bad   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h06};
        f_100   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h15};
        f_short = '{8'h11, 8'h22, 8'h33, 8'h44};
        f_long  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h07, 8'hAA, 8'hBB};
        f_part  = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h77};
        chk("pin_rem_one", 64'(rem8(f_one, 8)), 64'h07);
        chk("pin_rem_100", 64'(rem8(f_100, 8)), 64'h15);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send(f_zero, 1'b1);
        expect_word("zero", 64'h0, 1'b0, 1'b0, 0);
        retire();
        send(f_one, 1'b1);
        expect_word("one", 64'h1, 1'b0, 1'b0, 0);
        retire();
        send(f_bad, 1'b1);
        expect_word("bad_crc", 64'h1, 1'b1, 1'b0, 0);
        retire();
        send(f_100, 1'b1);
        expect_word("w100", 64'h100, 1'b0, 1'b0, 0);
        in_valid = 1'b1;
        in_data = 8'hFF;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, 64'h100);
            chk("hold_flags", {62'd0, out_crc_err, out_len_err}, 64'd0);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        retire();
        send(f_short, 1'b1);
        expect_word("short", 64'h11223344, 1'b1, 1'b1, 0);
        retire();
        send(f_one, 1'b1);
        expect_word("after_short", 64'h1, 1'b0, 1'b0, 0);
        retire();
        send(f_long, 1'b1);
        expect_word("long", 64'h1, 1'b0, 1'b1, 0);
        retire();
        send(f_part, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midframe_rst_valid", 64'(out_valid), 64'd0);
        chk("midframe_rst_data", out_data, 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        send(f_100, 1'b1);
        expect_word("after_rst", 64'h100, 1'b0, 1'b0, 0);
        #1 rst = 1'b1;
        #1;
        chk("hold_rst_valid", 64'(out_valid), 64'd0);
        chk("hold_rst_data", out_data, 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        send(f_zero, 1'b1);
        expect_word("after_hold_rst", 64'h0, 1'b0, 1'b0, 0);
        retire();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
